prefix_tree_pipelined_64b: RTL and testbench
============================================

// Module: prefix_tree_pipelined_64b
// PURPOSE
//  Pipelined Kogge-Stone carry network for the 64b parallel-prefix adder.
//  - Consumes per-bit propagate/generate vectors from the pre-processing stage (bit 0 = carry-in slot).
//  - Produces group-generate G[i:0] for every bit, plus the delayed per-bit propagate, to the post-processing (sum) stage.
//  - Valid/ready handshake with full backpressure; one result per cycle at full throughput.
// PARAMETERS
//  WIDTH      64  operand width; vectors are WIDTH+1 bits wide; LEVELS = $clog2(WIDTH+1) = 7
//  REG_EVERY  2   prefix levels per pipeline register, legal 1..LEVELS; latency L = ceil(LEVELS/REG_EVERY) = 4
// PORTS
//  clk_i      in   1        clock, all state on rising edge
//  rst_i      in   1        synchronous reset, active high
//  valid_i    in   1        upstream prop_i/gen_i valid
//  ready_o    out  1        block can accept this cycle
//  prop_i     in   WIDTH+1  per-bit propagate, prop_i[0]=0
//  gen_i      in   WIDTH+1  per-bit generate, gen_i[0]=carry-in
//  valid_o    out  1        result valid
//  ready_i    in   1        downstream accepts this cycle
//  gen_o      out  WIDTH+1  group generate G[i:0], i.e. carry out of bit i
//  prop_o     out  WIDTH+1  prop_i of the same transaction, delayed L stages
// BEHAVIOUR
//  - Reset (rst_i=1 at an edge): every stage valid <= 0, every data register <= 0. Outputs: valid_o=0, gen_o=0, prop_o=0.
//  - ready_o is forced to 0 while rst_i=1.
//  - Prefix operator: (g,p) o (g',p') = (g | p&g', p&p').
//    - Level k (k = 0..LEVELS-1), distance d = 2^k: bit i >= d combines with bit i-d; bits i < d pass through unchanged.
//    - After LEVELS levels, gen_o[i] = G[i:0] including carry-in.
//  - Pipeline: registers after levels REG_EVERY-1, 2*REG_EVERY-1, ..., and always after the final level.
//    - L register stages total; outputs come directly from the last stage.
//    - Each stage carries valid, running (g,p) and the original prop_i.
//  - Handshake, per stage s (stage L is the output):
//    - adv[L] = ready_i | ~v[L]; adv[s] = adv[s+1] | ~v[s].
//    - ready_o = adv[1] & ~rst_i (combinational, no registered bubble).
//    - Transfer into stage s when adv[s]: v[s] <= v[s-1] (valid_i for s=1), data loaded.
//    - Stage holds its data and valid when ~adv[s].
//  - Latency: a beat accepted at edge t appears on valid_o after edge t+L-1 when unstalled.
//    - Throughput is 1 beat/clock while ready_i=1. Bubbles collapse.
//  - Ordering: strictly FIFO. No beat is dropped or duplicated.
//  - Output stability: while valid_o=1 & ready_i=0, gen_o/prop_o/valid_o stay constant.
//  - Full: all L stages valid & ready_i=0 -> ready_o=0 the same cycle. Up to L beats buffered.
//  - Simultaneous: when full and ready_i rises, ready_o=1 the same cycle (accept and drain together).
//  - Input validity: valid_i is honoured without checking prop_i[0]. prop_i[0]=1 gives defined (operator-consistent) but unused results.
//  - Reset mid-operation: all in-flight beats are discarded. First post-reset output comes only from a beat accepted after rst_i falls.
//  - Data in stages with v=0 is don't-care, except after reset, when it is 0.
// TESTING
//  1. Full carry ripple: prop_i={64{1},0}, gen_i=65'h1 -> gen_o=all ones after L=4 cycles.
//  2. No carry: gen_i=0, random prop_i -> gen_o=0, prop_o==prop_i.
//  3. Adder model, 10k random a,b,cin:
//     - drive prop_i={a^b,0}, gen_i={a&b,cin};
//     - require {gen_o[64], prop_o[64:1]^gen_o[63:0]} == a+b+cin.
//  4. Backpressure: ready_i=0, push 6 beats -> ready_o=0 after beat 4.
//     - Raise ready_i: 6 results in order, no loss, outputs stable while stalled.
//  5. Streaming: valid_i=1, ready_i=1 for 100 beats -> first valid_o 4 cycles after first accept, then 100 consecutive results.
//  6. Reset at cycle 2 of 4 in-flight beats -> valid_o=0 and gen_o=prop_o=0 next cycle, ready_o=0 during reset.
//     Repeat tests 1/3 with REG_EVERY=1 (L=7) and REG_EVERY=7 (L=1).

Source files
------------

// File: rtl/prefix_tree_pipelined_64b.sv
// Pipelined Kogge-Stone group-generate network for a WIDTH-bit parallel-prefix adder.
// Bit 0 is the carry-in slot; a register follows every REG_EVERY prefix levels and the last level.
module prefix_tree_pipelined_64b #(
  parameter int WIDTH     = 64,
  parameter int REG_EVERY = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH:0]   prop_i,
  input  logic [WIDTH:0]   gen_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH:0]   gen_o,
  output logic [WIDTH:0]   prop_o
);

  localparam int LEVELS = $clog2(WIDTH + 1);
  localparam int L      = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  typedef logic [WIDTH:0] vec_t;

  // Stage registers, index 1..L; stage L drives the outputs.
  logic [L:1] v_q;
  vec_t       g_q  [1:L];
  vec_t       p_q  [1:L];
  vec_t       op_q [1:L];

  // Inputs seen by each stage: index 0 is the input port, s is register stage s.
  logic       st_v  [0:L-1];
  vec_t       st_g  [0:L-1];
  vec_t       st_p  [0:L-1];
  vec_t       st_op [0:L-1];

  vec_t       nxt_g [1:L];
  vec_t       nxt_p [1:L];
  logic [L:1] adv;
  vec_t       lg;
  vec_t       lp;

  always_comb begin : stage_sources
    st_v[0]  = valid_i;
    st_g[0]  = gen_i;
    st_p[0]  = prop_i;
    st_op[0] = prop_i;
    for (int s = 1; s < L; s++) begin
      st_v[s]  = v_q[s];
      st_g[s]  = g_q[s];
      st_p[s]  = p_q[s];
      st_op[s] = op_q[s];
    end
  end

  // Each stage applies its slice of levels; level k combines bit i with bit i-2^k,
  // the low 2^k bits pass through (g unchanged, p masked to keep itself).
  always_comb begin : prefix_levels
    // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
    lg = '0;
    lp = '0;
    for (int s = 1; s <= L; s++) begin
      lg = st_g[s-1];
      lp = st_p[s-1];
      for (int k = 0; k < LEVELS; k++) begin
        if (k >= (s - 1) * REG_EVERY && k < s * REG_EVERY) begin
          lg = lg | (lp & (lg << (1 << k)));
          lp = lp & ((lp << (1 << k)) | ((vec_t'(1) << (1 << k)) - vec_t'(1)));
        end
      end
      nxt_g[s] = lg;
      nxt_p[s] = lp;
    end
  end

  // A stage may load when the stage after it moves or when it is empty.
  always_comb begin : advance_chain
    adv    = '0;
    adv[L] = ready_i | ~v_q[L];
    for (int s = L - 1; s >= 1; s--) begin
      adv[s] = adv[s+1] | ~v_q[s];
    end
  end

  assign ready_o = adv[1] & ~rst_i;

  always_ff @(posedge clk_i) begin
    // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
    if (rst_i) begin
      v_q <= '0;
      // NOTE: data registers are cleared too, so outputs read as zero straight after reset.
      for (int s = 1; s <= L; s++) begin
        g_q[s]  <= '0;
        p_q[s]  <= '0;
        op_q[s] <= '0;
      end
    end else begin
      for (int s = 1; s <= L; s++) begin
        if (adv[s]) begin
          v_q[s] <= st_v[s-1];
          // Data only moves with a real beat, which keeps idle stages quiet.
          if (st_v[s-1]) begin
            g_q[s]  <= nxt_g[s];
            p_q[s]  <= nxt_p[s];
            op_q[s] <= st_op[s-1];
          end
        end
      end
    end
  end

  assign valid_o = v_q[L];
  assign gen_o   = g_q[L];
  assign prop_o  = op_q[L];

endmodule

// File: tb/tb_prefix_tree_pipelined_64b.sv
// Self-checking bench: three configurations (L=4, 7, 1) against a ripple-carry reference
// and plain integer addition, with directed latency, backpressure and reset steps.
module tb_prefix_tree_pipelined_64b;

  localparam int W = 64;

  logic         clk_i = 1'b0;
  logic         rst_i, valid_i, ready_i;
  logic [W:0]   prop_i, gen_i;
  logic         ready_o, valid_o;
  logic [W:0]   gen_o, prop_o;
  logic         x1_ready, x1_valid, x7_ready, x7_valid;
  logic [W:0]   x1_gen, x1_prop, x7_gen, x7_prop;
  logic         fire;

  assign fire = valid_i & ready_o;

  prefix_tree_pipelined_64b #(.WIDTH(W), .REG_EVERY(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .prop_i(prop_i), .gen_i(gen_i), .valid_o(valid_o), .ready_i(ready_i),
    .gen_o(gen_o), .prop_o(prop_o));

  prefix_tree_pipelined_64b #(.WIDTH(W), .REG_EVERY(1)) dut_l7 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(fire), .ready_o(x1_ready),
    .prop_i(prop_i), .gen_i(gen_i), .valid_o(x1_valid), .ready_i(1'b1),
    .gen_o(x1_gen), .prop_o(x1_prop));

  prefix_tree_pipelined_64b #(.WIDTH(W), .REG_EVERY(7)) dut_l1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(fire), .ready_o(x7_ready),
    .prop_i(prop_i), .gen_i(gen_i), .valid_o(x7_valid), .ready_i(1'b1),
    .gen_o(x7_gen), .prop_o(x7_prop));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W:0] g;
    logic [W:0] p;
    logic [W:0] sum;
    bit         add;
  } beat_t;

  beat_t      q2[$], q1[$], q7[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W:0] cur_sum  = '0;
  bit         cur_add  = 1'b0;
  bit         rnd_rdy  = 1'b0;

  // Carry out of bit i by plain ripple: G[i:0] = g[i] | p[i] & G[i-1:0].
  function automatic logic [W:0] prefix_ref(input logic [W:0] p, input logic [W:0] g);
    logic [W:0] r;
    r[0] = g[0];
    for (int i = 1; i <= W; i++) r[i] = g[i] | (p[i] & r[i-1]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input logic [W:0] go, input logic [W:0] po,
                         input beat_t e);
    check($sformatf("%s_gen", tag), go, e.g);
    check($sformatf("%s_prop", tag), po, e.p);
    if (e.add) check($sformatf("%s_sum", tag), {go[W], po[W:1] ^ go[W-1:0]}, e.sum);
  endtask

  // Scoreboard: outputs that will transfer at the next edge are compared, accepted beats queued.
  always @(negedge clk_i) begin
    beat_t e;
    if (!rst_i) begin
      if (valid_o && ready_i) begin
        if (q2.size() == 0) check1("m2_extra_beat", valid_o, 1'b0);
        else begin e = q2.pop_front(); cmp_out("m2", gen_o, prop_o, e); end
      end
      if (x1_valid) begin
        if (q1.size() == 0) check1("m7_extra_beat", x1_valid, 1'b0);
        else begin e = q1.pop_front(); cmp_out("m7", x1_gen, x1_prop, e); end
      end
      if (x7_valid) begin
        if (q7.size() == 0) check1("m1_extra_beat", x7_valid, 1'b0);
        else begin e = q7.pop_front(); cmp_out("m1", x7_gen, x7_prop, e); end
      end
      if (valid_i && ready_o) begin
        e.g   = prefix_ref(prop_i, gen_i);
        e.p   = prop_i;
        e.sum = cur_sum;
        e.add = cur_add;
        q2.push_back(e);
        q1.push_back(e);
        q7.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [W:0] p, input logic [W:0] g);
    int guard = 0;
    valid_i = 1'b1;
    prop_i  = p;
    gen_i   = g;
    @(negedge clk_i);
    while (!ready_o && guard < 200) begin
      step();
      if (rnd_rdy) ready_i = 1'($urandom_range(0, 1));
      guard++;
      @(negedge clk_i);
    end
    if (!ready_o) check1("send_timeout", ready_o, 1'b1);
    step();
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    rnd_rdy = 1'b0;
    while ((q2.size() != 0 || q1.size() != 0 || q7.size() != 0) && guard < 100) begin
      step();
      guard++;
    end
    step();
    check1("drain_empty", (q2.size() == 0) && (q1.size() == 0) && (q7.size() == 0), 1'b1);
  endtask

  function automatic logic [W:0] rnd_vec();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  // Single carry rippling from carry-in through all 64 propagate bits, with latency per config.
  task automatic ripple_test(input string tag);
    logic [W:0] ones;
    ones = '1;
    cur_add = 1'b0;
    ready_i = 1'b1;
    send({{W{1'b1}}, 1'b0}, 65'h1);
    for (int j = 0; j <= 6; j++) begin
      check1($sformatf("%s_lat4_%0d", tag, j), valid_o, j == 3);
      check1($sformatf("%s_lat7_%0d", tag, j), x1_valid, j == 6);
      check1($sformatf("%s_lat1_%0d", tag, j), x7_valid, j == 0);
      if (j == 3) check($sformatf("%s_all_ones", tag), gen_o, ones);
      step();
    end
    drain();
  endtask

  initial begin
    logic [63:0] a, b;
    logic        cin;

    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    prop_i  = '0;
    gen_i   = '0;
    repeat (3) step();
    check1("rst_ready", ready_o, 1'b0);
    check1("rst_valid", valid_o, 1'b0);
    check("rst_gen", gen_o, '0);
    check("rst_prop", prop_o, '0);
    check1("rst_valid_l7", x1_valid, 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check1("post_rst_ready", ready_o, 1'b1);
    check1("post_rst_ready_l7", x1_ready, 1'b1);
    check1("post_rst_ready_l1", x7_ready, 1'b1);
    step();

    ripple_test("ripple");

    // No generate anywhere: no carries, propagate passes through (including prop_i[0]=1).
    cur_add = 1'b0;
    for (int i = 0; i < 8; i++) send(rnd_vec(), '0);
    drain();

    // Adder model with random valid gaps and random downstream stalls.
    rnd_rdy = 1'b1;
    cur_add = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 4) == 0) step();
      ready_i = ($urandom_range(0, 3) != 0);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom);
      cur_sum = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      send({a ^ b, 1'b0}, {a & b, cin});
    end
    cur_add = 1'b0;
    drain();

    // Backpressure: four beats fill the pipe, the fifth waits; outputs hold while stalled.
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(rnd_vec(), rnd_vec());
    valid_i = 1'b1;
    prop_i  = rnd_vec();
    gen_i   = rnd_vec();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check1("full_ready", ready_o, 1'b0);
      check1("stall_valid", valid_o, 1'b1);
      check("stall_gen", gen_o, q2[0].g);
      check("stall_prop", prop_o, q2[0].p);
    end
    step();
    ready_i = 1'b1;
    @(negedge clk_i);
    check1("drain_accept_ready", ready_o, 1'b1);
    step();
    send(rnd_vec(), rnd_vec());
    drain();

    // Streaming: 100 back-to-back beats, first output 3 edges after the first accepting edge.
    ready_i = 1'b1;
    for (int j = 0; j <= 105; j++) begin
      if (j < 100) begin
        valid_i = 1'b1;
        prop_i  = rnd_vec();
        gen_i   = rnd_vec();
      end else valid_i = 1'b0;
      step();
      check1($sformatf("stream_v_%0d", j), valid_o, (j >= 3) && (j <= 102));
    end
    drain();

    // Reset with beats in flight: everything discarded, outputs cleared.
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      prop_i  = rnd_vec();
      gen_i   = rnd_vec();
      step();
    end
    valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    q2.delete();
    q1.delete();
    q7.delete();
    #1;
    check1("mid_rst_ready", ready_o, 1'b0);
    step();
    check1("mid_rst_valid", valid_o, 1'b0);
    check("mid_rst_gen", gen_o, '0);
    check("mid_rst_prop", prop_o, '0);
    check1("mid_rst_valid_l7", x1_valid, 1'b0);
    check1("mid_rst_valid_l1", x7_valid, 1'b0);
    check1("mid_rst_ready_hold", ready_o, 1'b0);
    rst_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      check1("post_rst_idle", valid_o | x1_valid | x7_valid, 1'b0);
    end

    ripple_test("ripple_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
